// File: rtl/otter_branch_predictor.sv
// rtl/otter_branch_predictor.sv - tagged BTB with saturating direction counters and invalidation sweep
// Optional performance counters enabled by defining BPRED_STATS_EN.
module otter_branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        FLUSH,
   input  logic [31:0] LK_PC,
   output logic        PRED_HIT,
   output logic        PRED_TAKEN,
   output logic [31:0] PRED_TARGET,
   input  logic        UPD_VALID,
   input  logic [31:0] UPD_PC,
   input  logic        UPD_TAKEN,
   input  logic [31:0] UPD_TARGET,
   input  logic        UPD_PRED_TAKEN,
   input  logic [31:0] UPD_PRED_TARGET,
   output logic        MISPREDICT,
   output logic        BUSY,
   output logic [31:0] BR_COUNT,
   output logic [31:0] MISS_COUNT
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WT   = {1'b1, {(CTR_W-1){1'b0}}};
   localparam logic [CTR_W-1:0] CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       sweep_idx_q;
   logic [ENTRIES-1:0]     valid_q;
   logic [TAG_W-1:0]       tag_q    [ENTRIES];
   logic [31:0]            target_q [ENTRIES];
   logic [CTR_W-1:0]       ctr_q    [ENTRIES];

   logic [IDX_W-1:0]       lk_idx, upd_idx;
   logic [TAG_W-1:0]       lk_tag, upd_tag;
   logic                   upd_hit;

   assign lk_idx  = LK_PC[IDX_W+1:2];
   assign lk_tag  = LK_PC[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_idx = UPD_PC[IDX_W+1:2];
   assign upd_tag = UPD_PC[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

   always_ff @(posedge CLK) begin
      if (!RESET_N) state_q <= SWEEP;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (FLUSH) state_d = SWEEP;
         SWEEP:   if (!FLUSH && sweep_idx_q == LAST_IDX) state_d = IDLE;
         default: state_d = SWEEP;
      endcase
   end

   always_comb begin
      BUSY = (state_q == SWEEP);
   end

   // FLUSH is level-sensitive: while held, the sweep stays pinned at index 0.
   always_ff @(posedge CLK) begin
      if (!RESET_N || FLUSH)   sweep_idx_q <= '0;
      else if (state_q == SWEEP) sweep_idx_q <= sweep_idx_q + IDX_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET_N) begin
         if (BUSY) begin
            valid_q[sweep_idx_q] <= 1'b0;
            ctr_q[sweep_idx_q]   <= CTR_WNT;
         end else if (UPD_VALID) begin
            if (upd_hit) begin
               if (UPD_TAKEN) begin
                  target_q[upd_idx] <= UPD_TARGET;
                  if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
               end else if (ctr_q[upd_idx] != '0) begin
                  ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
               end
            end else if (UPD_TAKEN) begin
               valid_q[upd_idx]  <= 1'b1;
               tag_q[upd_idx]    <= upd_tag;
               target_q[upd_idx] <= UPD_TARGET;
               ctr_q[upd_idx]    <= CTR_WT;
            end
         end
      end
   end

   always_comb begin
      PRED_HIT    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !BUSY;
      PRED_TAKEN  = PRED_HIT && ctr_q[lk_idx][CTR_W-1];
      PRED_TARGET = PRED_TAKEN ? target_q[lk_idx] : LK_PC + 32'd4;
   end

   assign MISPREDICT = UPD_VALID &&
                       ((UPD_TAKEN != UPD_PRED_TAKEN) ||
                        (UPD_TAKEN && UPD_PRED_TAKEN && (UPD_TARGET != UPD_PRED_TARGET)));

`ifdef BPRED_STATS_EN
   logic [31:0] br_count_q, miss_count_q;

   // Counted regardless of BUSY; only reset clears them.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         br_count_q   <= '0;
         miss_count_q <= '0;
      end else if (UPD_VALID) begin
         if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
         if (MISPREDICT && miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign BR_COUNT   = br_count_q;
   assign MISS_COUNT = miss_count_q;
`else
   assign BR_COUNT   = 32'd0;
   assign MISS_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_otter_branch_predictor.sv
// tb/tb_otter_branch_predictor.sv - directed self-checking bench for otter_branch_predictor
module tb_otter_branch_predictor;

   logic        CLK;
   logic        RESET_N;
   logic        FLUSH;
   logic [31:0] LK_PC;
   logic        PRED_HIT;
   logic        PRED_TAKEN;
   logic [31:0] PRED_TARGET;
   logic        UPD_VALID;
   logic [31:0] UPD_PC;
   logic        UPD_TAKEN;
   logic [31:0] UPD_TARGET;
   logic        UPD_PRED_TAKEN;
   logic [31:0] UPD_PRED_TARGET;
   logic        MISPREDICT;
   logic        BUSY;
   logic [31:0] BR_COUNT;
   logic [31:0] MISS_COUNT;

   int errors = 0;
   int checks = 0;
   int br_exp = 0;
   int miss_exp = 0;

   otter_branch_predictor #(.ENTRIES(64), .CTR_W(2), .TAG_W(8)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .LK_PC(LK_PC),
      .PRED_HIT(PRED_HIT), .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
      .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_TAKEN(UPD_TAKEN),
      .UPD_TARGET(UPD_TARGET), .UPD_PRED_TAKEN(UPD_PRED_TAKEN),
      .UPD_PRED_TARGET(UPD_PRED_TARGET), .MISPREDICT(MISPREDICT), .BUSY(BUSY),
      .BR_COUNT(BR_COUNT), .MISS_COUNT(MISS_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic look(input logic [31:0] pc);
      LK_PC = pc;
      #1;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      UPD_VALID       = 1'b1;
      UPD_PC          = pc;
      UPD_TAKEN       = taken;
      UPD_TARGET      = tgt;
      UPD_PRED_TAKEN  = 1'b0;
      UPD_PRED_TARGET = pc + 32'd4;
      br_exp++;
      if (taken) miss_exp++;
   endtask

   task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
      drive_upd(pc, taken, tgt);
      step;
      UPD_VALID = 1'b0;
   endtask

   task automatic expect_pred(input string name, input logic hit, input logic tk, input logic [31:0] tgt);
      checks++;
      if (PRED_HIT !== hit || PRED_TAKEN !== tk || PRED_TARGET !== tgt) begin
         errors++;
         $display("FAIL %s: got hit=%b taken=%b target=%h expected hit=%b taken=%b target=%h",
                  name, PRED_HIT, PRED_TAKEN, PRED_TARGET, hit, tk, tgt);
      end
   endtask

   task automatic test_reset;
      int cnt;
      RESET_N = 1'b0; FLUSH = 1'b0; UPD_VALID = 1'b0; UPD_PC = '0; UPD_TAKEN = 1'b0;
      UPD_TARGET = '0; UPD_PRED_TAKEN = 1'b0; UPD_PRED_TARGET = '0; LK_PC = 32'h100;
      step; step;
      RESET_N = 1'b1;
      #1;
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", BUSY); end
      expect_pred("reset_lookup", 1'b0, 1'b0, 32'h104);
      checks++;
      if (BR_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin
         errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", BR_COUNT, MISS_COUNT);
      end
      cnt = 0;
      while (BUSY === 1'b1 && cnt < 200) begin
         step;
         cnt++;
         if (cnt == 32) expect_pred("reset_mid_sweep_lookup", 1'b0, 1'b0, 32'h104);
      end
      checks++;
      if (cnt != 64) begin errors++; $display("FAIL reset_busy_cycles: got %0d expected 64", cnt); end
   endtask

   task automatic test_mispredict;
      UPD_VALID = 1'b1; UPD_PC = 32'h200; UPD_TAKEN = 1'b1; UPD_TARGET = 32'h400;
      UPD_PRED_TAKEN = 1'b1; UPD_PRED_TARGET = 32'h400;
      #1;
      checks++;
      if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL mp_correct: got %b expected 0", MISPREDICT); end
      UPD_PRED_TARGET = 32'h404;
      #1;
      checks++;
      if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL mp_target: got %b expected 1", MISPREDICT); end
      UPD_TAKEN = 1'b0;
      #1;
      checks++;
      if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL mp_direction: got %b expected 1", MISPREDICT); end
      UPD_VALID = 1'b0;
      #1;
      checks++;
      if (MISPREDICT !== 1'b0) begin errors++; $display("FAIL mp_novalid: got %b expected 0", MISPREDICT); end
   endtask

   task automatic test_alloc;
      look(32'h200);
      drive_upd(32'h200, 1'b1, 32'h400);
      #1;
      checks++;
      if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %b expected 1", MISPREDICT); end
      expect_pred("alloc_pre", 1'b0, 1'b0, 32'h204);
      step;
      UPD_VALID = 1'b0;
      look(32'h200);
      expect_pred("alloc_post", 1'b1, 1'b1, 32'h400);
   endtask

   task automatic test_counter;
      do_upd(32'h200, 1'b0, 32'h0); look(32'h200); expect_pred("ctr_nt1", 1'b1, 1'b0, 32'h204);
      do_upd(32'h200, 1'b0, 32'h0); look(32'h200); expect_pred("ctr_nt2", 1'b1, 1'b0, 32'h204);
      do_upd(32'h200, 1'b1, 32'h400); look(32'h200); expect_pred("ctr_t1", 1'b1, 1'b0, 32'h204);
      do_upd(32'h200, 1'b1, 32'h400); look(32'h200); expect_pred("ctr_t2", 1'b1, 1'b1, 32'h400);
      do_upd(32'h200, 1'b1, 32'h400); look(32'h200); expect_pred("ctr_t3", 1'b1, 1'b1, 32'h400);
      do_upd(32'h200, 1'b1, 32'h480); look(32'h200); expect_pred("ctr_t4_sat", 1'b1, 1'b1, 32'h480);
      do_upd(32'h200, 1'b0, 32'h0); look(32'h200); expect_pred("ctr_sat_nt1", 1'b1, 1'b1, 32'h480);
      do_upd(32'h200, 1'b0, 32'h0); look(32'h200); expect_pred("ctr_sat_nt2", 1'b1, 1'b0, 32'h204);
      do_upd(32'h200, 1'b0, 32'h0);
      do_upd(32'h200, 1'b0, 32'h0);
      do_upd(32'h200, 1'b1, 32'h400); look(32'h200); expect_pred("ctr_low_sat_t1", 1'b1, 1'b0, 32'h204);
      do_upd(32'h200, 1'b1, 32'h400); look(32'h200); expect_pred("ctr_low_sat_t2", 1'b1, 1'b1, 32'h400);
   endtask

   task automatic test_alias;
      do_upd(32'h300, 1'b1, 32'h600);
      look(32'h200); expect_pred("alias_old", 1'b0, 1'b0, 32'h204);
      look(32'h300); expect_pred("alias_new", 1'b1, 1'b1, 32'h600);
      do_upd(32'h500, 1'b0, 32'h0);
      look(32'h300); expect_pred("alias_nt_miss_nowrite", 1'b1, 1'b1, 32'h600);
      look(32'h302); expect_pred("alias_low_bits", 1'b1, 1'b1, 32'h600);
   endtask

   task automatic test_flush;
      int cnt;
      FLUSH = 1'b1;
      step;
      FLUSH = 1'b0;
      drive_upd(32'h1000, 1'b1, 32'h2000);
      #1;
      checks++;
      if (MISPREDICT !== 1'b1) begin errors++; $display("FAIL flush_busy_mispredict: got %b expected 1", MISPREDICT); end
      look(32'h300); expect_pred("flush_busy_lookup", 1'b0, 1'b0, 32'h304);
      step;
      UPD_VALID = 1'b0;
      repeat (9) step;
      FLUSH = 1'b1;
      step;
      FLUSH = 1'b0;
      cnt = 0;
      while (BUSY === 1'b1 && cnt < 200) begin
         if (cnt == 60) drive_upd(32'h1014, 1'b1, 32'h3000);
         step;
         UPD_VALID = 1'b0;
         cnt++;
      end
      checks++;
      if (cnt != 64) begin errors++; $display("FAIL flush_busy_cycles: got %0d expected 64", cnt); end
      look(32'h300);  expect_pred("flush_cleared_300", 1'b0, 1'b0, 32'h304);
      look(32'h200);  expect_pred("flush_cleared_200", 1'b0, 1'b0, 32'h204);
      look(32'h1014); expect_pred("flush_dropped_update", 1'b0, 1'b0, 32'h1018);
   endtask

   task automatic test_same_cycle;
      do_upd(32'h200, 1'b1, 32'h400);
      do_upd(32'h200, 1'b0, 32'h0);
      look(32'h200);
      drive_upd(32'h200, 1'b1, 32'h440);
      #1;
      expect_pred("same_cycle_before", 1'b1, 1'b0, 32'h204);
      step;
      UPD_VALID = 1'b0;
      #1;
      expect_pred("same_cycle_after", 1'b1, 1'b1, 32'h440);
   endtask

   task automatic test_stats;
      checks++;
`ifdef BPRED_STATS_EN
      if (BR_COUNT !== 32'(br_exp) || MISS_COUNT !== 32'(miss_exp)) begin
         errors++;
         $display("FAIL stats: got br=%0d miss=%0d expected br=%0d miss=%0d", BR_COUNT, MISS_COUNT, br_exp, miss_exp);
      end
`else
      if (BR_COUNT !== 32'd0 || MISS_COUNT !== 32'd0) begin
         errors++;
         $display("FAIL stats_tied: got br=%0d miss=%0d expected 0/0", BR_COUNT, MISS_COUNT);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_mispredict;
      test_alloc;
      test_counter;
      test_alias;
      test_stats;
      test_flush;
      test_stats;
      test_same_cycle;
      test_stats;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/otter_branch_predictor.md
# otter_branch_predictor

Parametrised branch-prediction unit for the pipelined OTTER core. It combines a direct-mapped, tagged branch target buffer with per-entry saturating direction counters. The IF stage queries it every cycle with the fetch PC; the EX stage writes back resolved branch and jump outcomes. The block includes a sequential invalidation sweep, triggered by reset or FLUSH, and optional performance counters. It lets the fetch stage redirect speculatively instead of always fetching PC+4.

## Interface
Parameters:
- ENTRIES, 64: BTB/counter table depth; power of two, at least 4; IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, 2 to 4.
- TAG_W, 8: stored tag width, 1 to (30 − IDX_W).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- FLUSH  in  1  request a full table invalidation sweep.
- LK_PC  in  32  fetch PC to look up.
- PRED_HIT  out  1  valid entry with a matching tag.
- PRED_TAKEN  out  1  predicted taken.
- PRED_TARGET  out  32  predicted next PC.
- UPD_VALID  in  1  resolved control-flow instruction present in EX.
- UPD_PC  in  32  PC of the resolved instruction.
- UPD_TAKEN  in  1  actual direction (1 for JAL/JALR).
- UPD_TARGET  in  32  actual taken target.
- UPD_PRED_TAKEN  in  1  prediction carried down the pipe with the instruction.
- UPD_PRED_TARGET  in  32  predicted target carried down the pipe.
- MISPREDICT  out  1  the resolved instruction was mispredicted.
- BUSY  out  1  invalidation sweep in progress.
- BR_COUNT  out  32  resolved control-flow instructions counted.
- MISS_COUNT  out  32  mispredictions counted.

## Operation
- Address mapping: index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]. PC[1:0] is ignored.
- Each entry holds: valid, tag, target[31:0], and ctr[CTR_W-1:0].
- Lookup is combinational from LK_PC against the registered table:
  - PRED_HIT = valid & tag match & !BUSY.
  - PRED_TAKEN = PRED_HIT & ctr[CTR_W-1].
  - PRED_TARGET = entry target when PRED_TAKEN, otherwise LK_PC+4 (modulo 2^32).
- MISPREDICT is combinational:
  - MISPREDICT = UPD_VALID & ((UPD_TAKEN != UPD_PRED_TAKEN) | (UPD_TAKEN & UPD_PRED_TAKEN & UPD_TARGET != UPD_PRED_TARGET)).
  - MISPREDICT is evaluated even while BUSY.
- Update, applied on the clock edge when UPD_VALID is high and BUSY is low:
  - Hit: ctr saturates up if taken and down if not taken (bounds 0 and 2^CTR_W−1). If taken, target ← UPD_TARGET.
  - Miss and taken: allocate (replace) the entry. valid=1, tag and target written, ctr = 2^(CTR_W−1) (weakly taken).
  - Miss and not taken: no table write.
- Invalidation FSM, states IDLE and SWEEP:
  - SWEEP clears valid[sweep_idx] and sets ctr to 2^(CTR_W−1)−1 (weakly not taken), one entry per cycle, with sweep_idx running 0 to ENTRIES−1.
  - IDLE→SWEEP when FLUSH=1; sweep_idx ← 0.
  - SWEEP→IDLE after clearing index ENTRIES−1.
  - FLUSH asserted during SWEEP restarts the sweep at 0.
  - BUSY = (state == SWEEP).
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents (read-before-write).

## Timing
- Reset: while RESET_N=0 at a clock edge, state ← SWEEP, sweep_idx ← 0, and the counters clear to 0. Table contents other than those cleared by the sweep are don't-care.
- After reset is released, BUSY stays 1 for exactly ENTRIES cycles and drops on the edge that completes index ENTRIES−1.
- During BUSY: PRED_HIT=0, PRED_TAKEN=0, PRED_TARGET=LK_PC+4, and updates are dropped.
- Reset asserted mid-sweep restarts the sweep from 0.
- Lookup latency is 0 cycles (combinational).
- An update becomes visible to lookups on the cycle after its edge.
- FLUSH needs to be asserted for only one cycle; it is level-sensitive, so holding it high keeps the sweep at index 0.

## Configuration
- BPRED_STATS_EN defined:
  - On every edge with UPD_VALID=1, BR_COUNT increments, and MISS_COUNT increments if MISPREDICT=1.
  - This happens regardless of BUSY.
  - Both counters saturate at 32'hFFFFFFFF.
  - Both are cleared by reset only, not by FLUSH.
- BPRED_STATS_EN undefined: no counter registers exist; BR_COUNT and MISS_COUNT are tied to 0.

## Test plan
- Reset then idle, ENTRIES=64 → BUSY=1 for 64 cycles after RESET_N rises. During that time, LK_PC=0x100 gives PRED_TARGET=0x104 and PRED_HIT=0.
- Update UPD_PC=0x200, taken, target 0x400, not predicted; next cycle look up 0x200 → MISPREDICT=1 on the update cycle. Lookup shows PRED_HIT=1, PRED_TAKEN=1, PRED_TARGET=0x400.
- Sequence on 0x200, CTR_W=2, after allocation: not taken twice → PRED_TAKEN=0 with PRED_HIT=1. Then three taken → ctr=3; a fourth taken → ctr stays 3 (saturation).
- Aliasing, ENTRIES=64, TAG_W=8: allocate 0x200, then taken update at 0x300 (same index, different tag) → lookup 0x200 gives PRED_HIT=0, lookup 0x300 gives PRED_HIT=1.
- FLUSH pulse at sweep index 10 → BUSY stays 1 for another 64 cycles. All prior entries then miss. With BPRED_STATS_EN, BR_COUNT and MISS_COUNT are unchanged by the flush.
- Same-cycle lookup and update on 0x200, taking ctr 1→2 → that cycle's PRED_TAKEN=0, next cycle's PRED_TAKEN=1.
